// File: rtl/vic_irq_cond_if.sv
// Request/config/status bundle between the interrupt conditioner and its neighbours.
// master drives raw requests, configuration and clear strobes; slave is the conditioner.
interface vic_irq_cond_if #(
    parameter int NUM_SRC = 32
);
    logic [NUM_SRC-1:0] irq_raw;
    logic [NUM_SRC-1:0] cfg_edge;
    logic [NUM_SRC-1:0] cfg_pol;
    logic [NUM_SRC-1:0] clr_pend;
    logic [NUM_SRC-1:0] vic_intr;
    logic [NUM_SRC-1:0] pend_status;
    logic [NUM_SRC-1:0] ovr_status;

    modport master (
        output irq_raw, cfg_edge, cfg_pol, clr_pend,
        input  vic_intr, pend_status, ovr_status
    );

    modport slave (
        input  irq_raw, cfg_edge, cfg_pol, clr_pend,
        output vic_intr, pend_status, ovr_status
    );
endinterface

// File: rtl/vic_irq_cond.sv
// IRQ conditioner: 2-flop sync, polarity, edge/level select, pending+overrun; 2-cycle latency, no backpressure.
// `IRQ_DEBOUNCE_EN adds a per-source DB_LEN-cycle stability filter (and DB_LEN cycles of latency).
module vic_irq_cond #(
    parameter int NUM_SRC = 32,
    parameter int DB_LEN  = 4
) (
    input logic           clk,
    input logic           rst,
    vic_irq_cond_if.slave bus
);
    if (DB_LEN < 1 || DB_LEN > 15) begin : g_bad_db_len
        $error("DB_LEN must be in 1..15");
    end

    logic [NUM_SRC-1:0] sync1;
    logic [NUM_SRC-1:0] sync2;
    logic [NUM_SRC-1:0] norm;
    logic [NUM_SRC-1:0] q;
    logic [NUM_SRC-1:0] prev;
    logic [NUM_SRC-1:0] pend;
    logic [NUM_SRC-1:0] ovr;
    logic [NUM_SRC-1:0] vic_intr;
    logic [NUM_SRC-1:0] edge_evt;
    logic [NUM_SRC-1:0] pend_nxt;
    logic [NUM_SRC-1:0] ovr_nxt;
    logic [NUM_SRC-1:0] intr_nxt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= bus.irq_raw;
            sync2 <= sync1;
        end
    end

    assign norm = sync2 ^ bus.cfg_pol;

`ifdef IRQ_DEBOUNCE_EN
    localparam logic [3:0] DB_LAST = 4'(DB_LEN - 1);

    logic [3:0]         db_cnt [NUM_SRC];
    logic [NUM_SRC-1:0] db_lvl;

    // A differing level must hold for DB_LEN consecutive cycles before it is taken.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            db_lvl <= '0;
            for (int i = 0; i < NUM_SRC; i++) begin
                db_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_SRC; i++) begin
                if (norm[i] == db_lvl[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DB_LAST) begin
                    db_lvl[i] <= norm[i];
                    db_cnt[i] <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + 4'd1;
                end
            end
        end
    end

    assign q = db_lvl;
`else
    assign q = norm;
`endif

    // A new event wins over a same-cycle clear so it is never lost; the overrun it
    // would have caused is dropped because software has just acknowledged the old one.
    always_comb begin
        edge_evt = q & ~prev & bus.cfg_edge;
        pend_nxt = bus.cfg_edge & (edge_evt | (pend & ~bus.clr_pend));
        ovr_nxt  = bus.cfg_edge & ~bus.clr_pend & (ovr | (edge_evt & pend));
        intr_nxt = (bus.cfg_edge & pend_nxt) | (~bus.cfg_edge & q);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prev     <= '0;
            pend     <= '0;
            ovr      <= '0;
            vic_intr <= '0;
        end else begin
            prev     <= q;
            pend     <= pend_nxt;
            ovr      <= ovr_nxt;
            vic_intr <= intr_nxt;
        end
    end

    assign bus.vic_intr    = vic_intr;
    assign bus.pend_status = pend;
    assign bus.ovr_status  = ovr;
endmodule

// File: tb/tb_vic_irq_cond.sv
// Bench for vic_irq_cond: table-driven per-cycle vectors through a scoreboard queue,
// plus hand-written reset-mid-operation and (with IRQ_DEBOUNCE_EN) debounce sequences.
module tb_vic_irq_cond;
    localparam int          NUM_SRC  = 32;
    localparam int          DB_LEN   = 4;
    localparam logic [31:0] IDLE     = 32'h0000_0080;
    localparam logic [31:0] CFG_EDGE = 32'h0000_002B;
    localparam logic [31:0] CFG_POL  = 32'h0000_0080;

    typedef struct {
        logic [31:0] raw;
        logic [31:0] clr;
        logic [31:0] e_intr;
        logic [31:0] e_pend;
        logic [31:0] e_ovr;
    } row_t;

    typedef struct {
        logic [31:0] intr;
        logic [31:0] pend;
        logic [31:0] ovr;
        int          tag;
    } exp_t;

    logic   clk = 1'b0;
    logic   rst = 1'b0;
    int     n_cmp = 0;
    int     n_fail = 0;
    row_t   tbl [$];
    exp_t   sb [$];

    vic_irq_cond_if #(.NUM_SRC(NUM_SRC)) bus ();

    vic_irq_cond #(.NUM_SRC(NUM_SRC), .DB_LEN(DB_LEN)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s[%0d]: got %h expected %h", name, tag, act, exp);
        end
    endtask

    task automatic add(input logic [31:0] raw, input logic [31:0] clr,
                       input logic [31:0] e_intr, input logic [31:0] e_pend, input logic [31:0] e_ovr);
        row_t r;
        r.raw = raw; r.clr = clr; r.e_intr = e_intr; r.e_pend = e_pend; r.e_ovr = e_ovr;
        tbl.push_back(r);
    endtask

    // Drive one cycle of inputs, queue what must be visible after the coming edge, then compare.
    task automatic step(input logic [31:0] raw, input logic [31:0] clr,
                        input logic [31:0] e_intr, input logic [31:0] e_pend, input logic [31:0] e_ovr,
                        input int tag);
        exp_t e;
        bus.irq_raw  = raw;
        bus.clr_pend = clr;
        e.intr = e_intr; e.pend = e_pend; e.ovr = e_ovr; e.tag = tag;
        sb.push_back(e);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            n_cmp++; n_fail++;
            $display("FAIL scoreboard_empty[%0d]: got 0 entries expected 1", tag);
        end else begin
            e = sb.pop_front();
            check("vic_intr", e.tag, bus.vic_intr, e.intr);
            check("pend_status", e.tag, bus.pend_status, e.pend);
            check("ovr_status", e.tag, bus.ovr_status, e.ovr);
        end
    endtask

    task automatic idle_cycles(input int n);
        bus.irq_raw  = IDLE;
        bus.clr_pend = '0;
        repeat (n) @(posedge clk);
        #1;
    endtask

`ifdef IRQ_DEBOUNCE_EN
    // A pulse of 'width' cycles on source 1; captured only if it outlasts the filter.
    task automatic db_pulse(input int width, input bit capture, input int base);
        for (int j = 0; j < 10; j++) begin
            logic [31:0] e;
            e = (capture && j >= 2 + DB_LEN) ? 32'h2 : 32'h0;
            step((j < width) ? (IDLE | 32'h2) : IDLE, '0, e, e, '0, base + j);
        end
        step(IDLE, 32'h2, '0, '0, '0, base + 10);
        idle_cycles(6);
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.irq_raw  = IDLE;
        bus.cfg_edge = CFG_EDGE;
        bus.cfg_pol  = CFG_POL;
        bus.clr_pend = '0;
        #7;
        check("reset_intr", 0, bus.vic_intr, '0);
        check("reset_pend", 0, bus.pend_status, '0);
        check("reset_ovr", 0, bus.ovr_status, '0);
        #15 rst = 1'b1;
        idle_cycles(5);
        check("idle_intr", 0, bus.vic_intr, '0);
        check("idle_pend", 0, bus.pend_status, '0);

`ifndef IRQ_DEBOUNCE_EN
        // Edge capture on source 3, clear, no re-trigger while held high.
        add(IDLE,  '0,  '0,  '0,  '0);
        add(32'h88,'0,  '0,  '0,  '0);
        add(32'h88,'0,  '0,  '0,  '0);
        add(32'h88,'0,  32'h08, 32'h08, '0);
        add(32'h88,'0,  32'h08, 32'h08, '0);
        add(32'h88,32'h08, '0, '0,  '0);
        add(32'h88,'0,  '0,  '0,  '0);
        add(32'h88,'0,  '0,  '0,  '0);
        add(IDLE,  '0,  '0,  '0,  '0);
        add(IDLE,  '0,  '0,  '0,  '0);
        // Overrun on source 0: two 3-cycle pulses, then a single clear.
        add(32'h81,'0,  '0,  '0,  '0);
        add(32'h81,'0,  '0,  '0,  '0);
        add(32'h81,'0,  32'h01, 32'h01, '0);
        add(IDLE,  '0,  32'h01, 32'h01, '0);
        add(IDLE,  '0,  32'h01, 32'h01, '0);
        add(32'h81,'0,  32'h01, 32'h01, '0);
        add(32'h81,'0,  32'h01, 32'h01, '0);
        add(32'h81,'0,  32'h01, 32'h01, 32'h01);
        add(IDLE,  '0,  32'h01, 32'h01, 32'h01);
        add(IDLE,  32'h01, '0, '0,  '0);
        add(IDLE,  '0,  '0,  '0,  '0);
        // Set/clear collision on source 5.
        add(32'hA0,'0,  '0,  '0,  '0);
        add(IDLE,  '0,  '0,  '0,  '0);
        add(IDLE,  '0,  32'h20, 32'h20, '0);
        add(IDLE,  '0,  32'h20, 32'h20, '0);
        add(32'hA0,'0,  32'h20, 32'h20, '0);
        add(32'hA0,'0,  32'h20, 32'h20, '0);
        add(IDLE,  32'h20, 32'h20, 32'h20, '0);
        add(IDLE,  '0,  32'h20, 32'h20, '0);
        add(IDLE,  32'h20, '0, '0,  '0);
        add(IDLE,  '0,  '0,  '0,  '0);
        // Level mode, active-low, source 7: six cycles low on the pin, clear ignored.
        add(IDLE,  '0,  '0,  '0,  '0);
        add(32'h00,'0,  '0,  '0,  '0);
        add(32'h00,'0,  '0,  '0,  '0);
        add(32'h00,'0,  32'h80, '0, '0);
        add(32'h00,32'h80, 32'h80, '0, '0);
        add(32'h00,'0,  32'h80, '0, '0);
        add(32'h00,'0,  32'h80, '0, '0);
        add(IDLE,  '0,  32'h80, '0, '0);
        add(IDLE,  '0,  32'h80, '0, '0);
        add(IDLE,  '0,  '0,  '0,  '0);
        add(IDLE,  '0,  '0,  '0,  '0);

        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i].raw, tbl[i].clr, tbl[i].e_intr, tbl[i].e_pend, tbl[i].e_ovr, i);
        end

        // Reset mid-operation with the upper half pending.
        bus.irq_raw  = '0;
        bus.cfg_pol  = '0;
        bus.cfg_edge = 32'hFFFF_0000;
        bus.clr_pend = 32'hFFFF_FFFF;
        repeat (4) @(posedge clk);
        #1;
        bus.clr_pend = '0;
        bus.irq_raw  = 32'hFFFF_0000;
        repeat (4) @(posedge clk);
        #1;
        check("pre_rst_pend", 100, bus.pend_status, 32'hFFFF_0000);
        check("pre_rst_intr", 100, bus.vic_intr, 32'hFFFF_0000);
        check("pre_rst_ovr", 100, bus.ovr_status, '0);
        #3 rst = 1'b0;
        #1;
        check("async_rst_intr", 101, bus.vic_intr, '0);
        check("async_rst_pend", 101, bus.pend_status, '0);
        check("async_rst_ovr", 101, bus.ovr_status, '0);
        @(posedge clk);
        #4 rst = 1'b1;
        @(posedge clk); #1;
        check("rerel_pend_e1", 102, bus.pend_status, '0);
        @(posedge clk); #1;
        check("rerel_pend_e2", 103, bus.pend_status, '0);
        @(posedge clk); #1;
        check("rerel_pend_e3", 104, bus.pend_status, 32'hFFFF_0000);
        check("rerel_intr_e3", 104, bus.vic_intr, 32'hFFFF_0000);
        check("rerel_ovr_e3", 104, bus.ovr_status, '0);
`else
        db_pulse(3, 1'b0, 200);
        db_pulse(4, 1'b1, 300);
`endif

        if (sb.size() != 0) begin
            n_cmp++; n_fail++;
            $display("FAIL scoreboard_left: got %0d entries expected 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
